// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: quotient to LO, remainder to HI, stalls ex while busy.
// Optional DIV_BYZERO_TRAP_EN: adds div_zero_out and an all-ones quotient / dividend remainder on divide-by-zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an accepted start
// ZERO  | divisor was zero, load the divide-by-zero result
// ON    | one restoring step per cycle, DATA_WIDTH steps
// END   | signed fix-up, register results, pulse ready_out
module div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic                  signed_in,
    input  logic                  annul_in,
    input  logic [DATA_WIDTH-1:0] dividend_in,
    input  logic [DATA_WIDTH-1:0] divisor_in,
    output logic [DATA_WIDTH-1:0] quotient_out,
    output logic [DATA_WIDTH-1:0] remainder_out,
    output logic                  ready_out,
`ifdef DIV_BYZERO_TRAP_EN
    output logic                  div_zero_out,
`endif
    output logic                  busy_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ZERO = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_END  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [1:0]            state;
    logic [CNT_WIDTH-1:0]  counter;
    logic [DATA_WIDTH-1:0] q_reg;
    logic [DATA_WIDTH-1:0] rem_reg;
    logic [DATA_WIDTH-1:0] dsr_reg;
    logic                  neg_q;
    logic                  neg_r;
    logic                  accept;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] dvd_mag;
    logic [DATA_WIDTH-1:0] dsr_mag;
`ifdef DIV_BYZERO_TRAP_EN
    logic                  zero_flag;
`endif

    assign accept   = (state == ST_IDLE) & start_in & ~annul_in & ~ready_out;
    assign busy_out = accept | (state != ST_IDLE);

    assign dvd_mag = (signed_in && dividend_in[DATA_WIDTH-1]) ? -dividend_in : dividend_in;
    assign dsr_mag = (signed_in && divisor_in[DATA_WIDTH-1])  ? -divisor_in  : divisor_in;

    // Partial remainder is DATA_WIDTH+1 bits; the borrow of the trial subtract decides the quotient bit.
    assign shifted = {rem_reg, q_reg[DATA_WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            counter       <= '0;
            q_reg         <= '0;
            rem_reg       <= '0;
            dsr_reg       <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            quotient_out  <= '0;
            remainder_out <= '0;
            ready_out     <= 1'b0;
`ifdef DIV_BYZERO_TRAP_EN
            zero_flag     <= 1'b0;
            div_zero_out  <= 1'b0;
`endif
        end else begin
            ready_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        counter <= '0;
                        rem_reg <= '0;
                        dsr_reg <= dsr_mag;
`ifdef DIV_BYZERO_TRAP_EN
                        div_zero_out <= 1'b0;
                        zero_flag    <= (divisor_in == '0);
`endif
                        if (divisor_in == '0) begin
                            // raw dividend kept so the trap result can return it unmodified
                            q_reg <= dividend_in;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= ST_ZERO;
                        end else begin
                            q_reg <= dvd_mag;
                            neg_q <= signed_in & (dividend_in[DATA_WIDTH-1] ^ divisor_in[DATA_WIDTH-1]);
                            neg_r <= signed_in & dividend_in[DATA_WIDTH-1];
                            state <= ST_ON;
                        end
                    end
                end
                ST_ON: begin
                    if (annul_in) begin
                        state <= ST_IDLE;
                    end else begin
                        rem_reg <= diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
                        q_reg   <= {q_reg[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
                        counter <= counter + 1'b1;
                        if (counter == LAST_STEP) begin
                            state <= ST_END;
                        end
                    end
                end
                ST_ZERO: begin
                    if (annul_in) begin
                        state <= ST_IDLE;
                    end else begin
`ifdef DIV_BYZERO_TRAP_EN
                        rem_reg <= q_reg;
                        q_reg   <= '1;
`else
                        rem_reg <= '0;
                        q_reg   <= '0;
`endif
                        state <= ST_END;
                    end
                end
                default: begin
                    if (!annul_in) begin
                        quotient_out  <= neg_q ? -q_reg : q_reg;
                        remainder_out <= neg_r ? -rem_reg : rem_reg;
                        ready_out     <= 1'b1;
`ifdef DIV_BYZERO_TRAP_EN
                        div_zero_out  <= zero_flag;
`endif
                    end
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (DATA_WIDTH=32): directed cases plus randomized DIV/DIVU against an
// arithmetic reference model. Builds with or without DIV_BYZERO_TRAP_EN.
module tb_div_unit;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          start_in;
    logic          signed_in;
    logic          annul_in;
    logic [DW-1:0] dividend_in;
    logic [DW-1:0] divisor_in;
    logic [DW-1:0] quotient_out;
    logic [DW-1:0] remainder_out;
    logic          ready_out;
    logic          busy_out;
`ifdef DIV_BYZERO_TRAP_EN
    logic          div_zero_out;
`endif

    int n_cmp;
    int n_err;
    logic [DW-1:0] last_q;
    logic [DW-1:0] last_r;

    div_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_in      (start_in),
        .signed_in     (signed_in),
        .annul_in      (annul_in),
        .dividend_in   (dividend_in),
        .divisor_in    (divisor_in),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out),
        .ready_out     (ready_out),
`ifdef DIV_BYZERO_TRAP_EN
        .div_zero_out  (div_zero_out),
`endif
        .busy_out      (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; SV truncates toward zero and % follows the dividend sign.
    task automatic ref_div(input logic sg, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output logic [DW-1:0] q, output logic [DW-1:0] r);
        longint sa, sb, lq, lr;
        if (b == 0) begin
`ifdef DIV_BYZERO_TRAP_EN
            q = '1;
            r = a;
`else
            q = '0;
            r = '0;
`endif
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q = lq[DW-1:0];
            r = lr[DW-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic run_div(input logic sg, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] eq, er;
        int lat, busy_bad, exp_lat;
        logic seen;
        ref_div(sg, a, b, eq, er);
        exp_lat = (b == 0) ? 2 : DW + 1;
        @(negedge clk);
        start_in    = 1'b1;
        signed_in   = sg;
        dividend_in = a;
        divisor_in  = b;
        #1 check_val("busy_at_start", 32'(busy_out), 32'd1);
        @(posedge clk);
        seen = 1'b0;
        lat = 0;
        busy_bad = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ready_out) begin
                seen = 1'b1;
                lat  = i;
            end else if (!busy_out) begin
                busy_bad++;
            end
        end
        check_val("ready_seen", 32'(seen), 32'd1);
        check_val("latency", lat, exp_lat);
        check_val("busy_during_run", busy_bad, 0);
        check_val("busy_in_ready_cycle", 32'(busy_out), 32'd0);
        check_val("quotient", quotient_out, eq);
        check_val("remainder", remainder_out, er);
`ifdef DIV_BYZERO_TRAP_EN
        check_val("div_zero", 32'(div_zero_out), (b == 0) ? 32'd1 : 32'd0);
`endif
        start_in = 1'b0;
        @(posedge clk);
        #1 check_val("ready_one_cycle", 32'(ready_out), 32'd0);
        last_q = eq;
        last_r = er;
    endtask

    function automatic logic [DW-1:0] pick_operand(input bit allow_zero);
        logic [DW-1:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'h8000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'd1;
            3: v = allow_zero ? 32'd0 : 32'd3;
            4: v = $urandom_range(1, 1000);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int ready_cnt;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start_in = 1'b0;
        signed_in = 1'b0;
        annul_in = 1'b0;
        dividend_in = '0;
        divisor_in = '0;
        last_q = '0;
        last_r = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_quotient", quotient_out, 32'd0);
        check_val("rst_remainder", remainder_out, 32'd0);
        check_val("rst_ready", 32'(ready_out), 32'd0);
        check_val("rst_busy", 32'(busy_out), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_div(1'b0, 32'd100, 32'd7);
        check_val("divu_100_7_q", quotient_out, 32'd14);
        run_div(1'b1, -32'sd7, 32'd2);
        check_val("div_m7_2_q", quotient_out, 32'hFFFF_FFFD);
        check_val("div_m7_2_r", remainder_out, 32'hFFFF_FFFF);
        run_div(1'b1, 32'd7, -32'sd2);
        check_val("div_7_m2_r", remainder_out, 32'd1);
        run_div(1'b1, 32'd5, 32'd0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check_val("div_ovf_q", quotient_out, 32'h8000_0000);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        check_val("divu_big_r", remainder_out, 32'h8000_0000);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1);

        // annul mid-run: no result, outputs untouched, next divide clean
        @(negedge clk);
        start_in = 1'b1; signed_in = 1'b0; dividend_in = 32'd1000; divisor_in = 32'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_in = 1'b1;
        start_in = 1'b0;
        @(posedge clk);
        #1 check_val("annul_idle_busy", 32'(busy_out), 32'd0);
        @(negedge clk) annul_in = 1'b0;
        ready_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (ready_out) ready_cnt++;
        end
        check_val("annul_no_ready", ready_cnt, 0);
        check_val("annul_keep_q", quotient_out, last_q);
        check_val("annul_keep_r", remainder_out, last_r);
        run_div(1'b0, 32'd9, 32'd3);
        check_val("after_annul_q", quotient_out, 32'd3);

        // async reset mid-run
        @(negedge clk);
        start_in = 1'b1; signed_in = 1'b1; dividend_in = 32'd12345; divisor_in = 32'd17;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        start_in = 1'b0;
        #1;
        check_val("arst_quotient", quotient_out, 32'd0);
        check_val("arst_remainder", remainder_out, 32'd0);
        check_val("arst_busy", 32'(busy_out), 32'd0);
`ifdef DIV_BYZERO_TRAP_EN
        check_val("arst_div_zero", 32'(div_zero_out), 32'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        ready_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (ready_out || busy_out) ready_cnt++;
        end
        check_val("arst_no_ready", ready_cnt, 0);
        last_q = '0;
        last_r = '0;

        for (int n = 0; n < 40; n++) begin
            logic sg;
            logic [DW-1:0] a, b;
            sg = 1'($urandom_range(0, 1));
            a  = pick_operand(1'b1);
            b  = ($urandom_range(0, 9) == 0) ? 32'd0 : pick_operand(1'b0);
            run_div(sg, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
